// File: rtl/arp_lookup_rewrite.sv
// Output-port lookup stage: resolves the LPM next hop through a 32-entry ARP table and
// rewrites the header beat (dst MAC, TTL, checksum, TUSER dst port) or steers it to the CPU.
module arp_lookup_rewrite #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int SRC_PORT_POS         = 16,
    parameter int DST_PORT_POS         = 24
) (
    input  logic                                AXI_ACLK,
    input  logic                                AXI_RESETN,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
    input  logic                                S_AXIS_TVALID,
    input  logic                                S_AXIS_TLAST,
    output logic                                S_AXIS_TREADY,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
    output logic                                M_AXIS_TVALID,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY,

    input  logic                                arp_lookup,
    input  logic [31:0]                         nh_reg,
    input  logic [31:0]                         oq_reg,

    input  logic                                tbl_wr_req,
    input  logic                                tbl_rd_req,
    input  logic [4:0]                          tbl_wr_addr,
    input  logic [4:0]                          tbl_rd_addr,
    input  logic [79:0]                         tbl_wr_data,
    output logic [79:0]                         tbl_rd_data,
    output logic                                tbl_wr_ack,
    output logic                                tbl_rd_ack,

    input  logic [31:0]                         reset,
    output logic [31:0]                         arp_miss_count
);

    localparam int DataW = C_S_AXIS_DATA_WIDTH;
    localparam int StrbW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UserW = C_S_AXIS_TUSER_WIDTH;
    localparam int FifoW = DataW + StrbW + UserW + 1;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StLookup  = 2'd1;
    localparam logic [1:0] StHeader  = 2'd2;
    localparam logic [1:0] StPayload = 2'd3;

    logic [1:0] state_q, state_d;

    // Input FIFO (depth 4, fall-through)
    logic [FifoW-1:0] fifo_mem [4];
    logic [1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]       count_q, count_d;
    logic             push, pop, empty, nearly_full, s_ready;

    logic [DataW-1:0] head_data;
    logic [StrbW-1:0] head_strb;
    logic [UserW-1:0] head_user;
    logic             head_last;

    assign empty       = (count_q == 3'd0);
    assign nearly_full = (count_q >= 3'd3);
    assign s_ready     = AXI_RESETN & ~nearly_full;
    assign S_AXIS_TREADY = s_ready;
    assign push        = S_AXIS_TVALID & s_ready;
    assign {head_data, head_strb, head_user, head_last} = fifo_mem[rd_ptr_q];

    always_ff @(posedge AXI_ACLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TUSER, S_AXIS_TLAST};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + 2'(push);
        rd_ptr_d = rd_ptr_q + 2'(pop);
        count_d  = count_q + 3'(push) - 3'(pop);
    end

    // ARP table; an entry with ip == 0 is invalid
    logic [79:0] tbl_q [32];
    logic [79:0] tbl_d [32];
    logic [79:0] rd_data_q, rd_data_d;
    logic        wr_ack_q, rd_ack_q;

    always_comb begin
        tbl_d = tbl_q;
        if (tbl_wr_req) begin
            tbl_d[tbl_wr_addr] = tbl_wr_data;
        end
        rd_data_d = tbl_rd_req ? tbl_q[tbl_rd_addr] : rd_data_q;
    end

    // Descending scan so the lowest matching index is the final assignment
    logic        hit;
    logic [47:0] hit_mac;

    always_comb begin
        hit     = 1'b0;
        hit_mac = '0;
        for (int i = 31; i >= 0; i--) begin
            if (tbl_q[i][31:0] != 32'd0 && tbl_q[i][31:0] == nh_reg) begin
                hit     = 1'b1;
                hit_mac = tbl_q[i][79:32];
            end
        end
    end

    logic       oq_ok;
    logic [7:0] oq_dst;

    always_comb begin
        oq_ok  = 1'b1;
        oq_dst = 8'h00;
        case (oq_reg)
            32'd0:   oq_dst = 8'h01;
            32'd1:   oq_dst = 8'h04;
            32'd2:   oq_dst = 8'h10;
            32'd3:   oq_dst = 8'h40;
            32'd4:   oq_dst = 8'h02;
            default: oq_ok  = 1'b0;
        endcase
    end

    logic [7:0] cpu_dst;

    always_comb begin
        if (head_user[SRC_PORT_POS + 6])      cpu_dst = 8'h80;
        else if (head_user[SRC_PORT_POS + 4]) cpu_dst = 8'h20;
        else if (head_user[SRC_PORT_POS + 2]) cpu_dst = 8'h08;
        else if (head_user[SRC_PORT_POS])     cpu_dst = 8'h02;
        else                                  cpu_dst = 8'h00;
    end

    // Incremental checksum update for TTL-1 with end-around carry
    logic [16:0] csum_sum;
    logic [15:0] csum_new;

    always_comb begin
        csum_sum = {1'b0, head_data[63:48]} + 17'h00100;
        csum_new = csum_sum[15:0] + {15'd0, csum_sum[16]};
    end

    logic [DataW-1:0] hdr_data_q, hdr_data_d;
    logic [StrbW-1:0] hdr_strb_q, hdr_strb_d;
    logic [UserW-1:0] hdr_user_q, hdr_user_d;
    logic             hdr_last_q, hdr_last_d;
    logic             miss;

    always_comb begin
        hdr_data_d = hdr_data_q;
        hdr_strb_d = hdr_strb_q;
        hdr_user_d = hdr_user_q;
        hdr_last_d = hdr_last_q;
        miss       = 1'b0;
        if (state_q == StLookup) begin
            hdr_data_d = head_data;
            hdr_strb_d = head_strb;
            hdr_user_d = head_user;
            hdr_last_d = head_last;
            if (arp_lookup) begin
                if (hit && oq_ok) begin
                    hdr_data_d[DataW-1 -: 48]       = hit_mac;
                    hdr_data_d[79:72]               = head_data[79:72] - 8'd1;
                    hdr_data_d[63:48]               = csum_new;
                    hdr_user_d[DST_PORT_POS +: 8]   = oq_dst;
                end else begin
                    miss                            = 1'b1;
                    hdr_user_d[DST_PORT_POS +: 8]   = cpu_dst;
                end
            end
        end
    end

    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (reset == 32'd1) begin
            miss_cnt_d = 32'd0;
        end else if (miss) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    logic m_valid;

    always_comb begin
        m_valid = 1'b0;
        case (state_q)
            StHeader:  m_valid = 1'b1;
            StPayload: m_valid = ~empty;
            default:   m_valid = 1'b0;
        endcase
        pop = m_valid & M_AXIS_TREADY;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (!empty) state_d = StLookup;
            StLookup:  state_d = StHeader;
            StHeader:  if (M_AXIS_TREADY) state_d = hdr_last_q ? StIdle : StPayload;
            StPayload: if (pop && head_last) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            hdr_data_q <= '0;
            hdr_strb_q <= '0;
            hdr_user_q <= '0;
            hdr_last_q <= 1'b0;
            miss_cnt_q <= '0;
            rd_data_q  <= '0;
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            hdr_data_q <= hdr_data_d;
            hdr_strb_q <= hdr_strb_d;
            hdr_user_q <= hdr_user_d;
            hdr_last_q <= hdr_last_d;
            miss_cnt_q <= miss_cnt_d;
            rd_data_q  <= rd_data_d;
            wr_ack_q   <= tbl_wr_req;
            rd_ack_q   <= tbl_rd_req;
            for (int i = 0; i < 32; i++) begin
                tbl_q[i] <= tbl_d[i];
            end
        end
    end

    assign M_AXIS_TVALID  = m_valid;
    assign M_AXIS_TDATA   = (state_q == StHeader) ? hdr_data_q : head_data;
    assign M_AXIS_TSTRB   = (state_q == StHeader) ? hdr_strb_q : head_strb;
    assign M_AXIS_TUSER   = (state_q == StHeader) ? hdr_user_q : head_user;
    assign M_AXIS_TLAST   = (state_q == StHeader) ? hdr_last_q : head_last;
    assign tbl_rd_data    = rd_data_q;
    assign tbl_wr_ack     = wr_ack_q;
    assign tbl_rd_ack     = rd_ack_q;
    assign arp_miss_count = miss_cnt_q;

endmodule

// File: tb/tb_arp_lookup_rewrite.sv
// Bench for arp_lookup_rewrite: directed scenarios plus randomized packets checked against
// a behavioural ARP/rewrite model.
module tb_arp_lookup_rewrite;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] s_tdata;
    logic [31:0]  s_tstrb;
    logic [127:0] s_tuser;
    logic         s_tvalid, s_tlast, s_tready;
    logic [255:0] m_tdata;
    logic [31:0]  m_tstrb;
    logic [127:0] m_tuser;
    logic         m_tvalid, m_tlast, m_tready;
    logic         arp_lookup;
    logic [31:0]  nh_reg, oq_reg;
    logic         tbl_wr_req, tbl_rd_req;
    logic [4:0]   tbl_wr_addr, tbl_rd_addr;
    logic [79:0]  tbl_wr_data, tbl_rd_data;
    logic         tbl_wr_ack, tbl_rd_ack;
    logic [31:0]  reset_cnt, miss_cnt;

    arp_lookup_rewrite dut (
        .AXI_ACLK       (clk),
        .AXI_RESETN     (rst_n),
        .S_AXIS_TDATA   (s_tdata),
        .S_AXIS_TSTRB   (s_tstrb),
        .S_AXIS_TUSER   (s_tuser),
        .S_AXIS_TVALID  (s_tvalid),
        .S_AXIS_TLAST   (s_tlast),
        .S_AXIS_TREADY  (s_tready),
        .M_AXIS_TDATA   (m_tdata),
        .M_AXIS_TSTRB   (m_tstrb),
        .M_AXIS_TUSER   (m_tuser),
        .M_AXIS_TVALID  (m_tvalid),
        .M_AXIS_TLAST   (m_tlast),
        .M_AXIS_TREADY  (m_tready),
        .arp_lookup     (arp_lookup),
        .nh_reg         (nh_reg),
        .oq_reg         (oq_reg),
        .tbl_wr_req     (tbl_wr_req),
        .tbl_rd_req     (tbl_rd_req),
        .tbl_wr_addr    (tbl_wr_addr),
        .tbl_rd_addr    (tbl_rd_addr),
        .tbl_wr_data    (tbl_wr_data),
        .tbl_rd_data    (tbl_rd_data),
        .tbl_wr_ack     (tbl_wr_ack),
        .tbl_rd_ack     (tbl_rd_ack),
        .reset          (reset_cnt),
        .arp_miss_count (miss_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] mdl_ip  [32];
    logic [47:0] mdl_mac [32];
    logic [7:0]  oq_tab  [5];
    logic [31:0] mdl_cnt;

    // Expected and observed beat streams
    logic [255:0] e_data[$];
    logic [127:0] e_user[$];
    logic         e_last[$];
    logic [255:0] q_data[$];
    logic [127:0] q_user[$];
    logic         q_last[$];
    int           q_cyc[$];

    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) begin
            q_data.push_back(m_tdata);
            q_user.push_back(m_tuser);
            q_last.push_back(m_tlast);
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Behavioural rewrite rules
    function automatic void model(input logic [255:0] d, input logic [127:0] u, input logic lk,
                                  input logic [31:0] nh, input logic [31:0] oq,
                                  output logic [255:0] od, output logic [127:0] ou,
                                  output bit miss);
        int idx = -1;
        int s;
        logic [7:0] dst;
        od = d;
        ou = u;
        miss = 0;
        if (!lk) return;
        for (int i = 0; i < 32; i++) begin
            if (idx < 0 && mdl_ip[i] != 0 && mdl_ip[i] == nh) idx = i;
        end
        if (idx >= 0 && oq < 5) begin
            od[255:208] = mdl_mac[idx];
            od[79:72]   = 8'((int'(d[79:72]) + 255) % 256);
            s = int'(d[63:48]) + 256;
            if (s > 65535) s = s - 65535;
            od[63:48]   = 16'(s);
            ou[31:24]   = oq_tab[oq[2:0]];
        end else begin
            miss = 1;
            dst = 8'h00;
            for (int b = 0; b < 8; b += 2) begin
                if (u[16 + b]) dst = 8'(1 << (b + 1));
            end
            ou[31:24] = dst;
        end
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic tbl_write(input int idx, input logic [79:0] data);
        sync();
        tbl_wr_req = 1; tbl_wr_addr = 5'(idx); tbl_wr_data = data;
        sync();
        tbl_wr_req = 0;
        check("wr_ack", tbl_wr_ack, 1);
        mdl_ip[idx]  = data[31:0];
        mdl_mac[idx] = data[79:32];
    endtask

    task automatic tbl_read(input string tag, input int idx, input logic [79:0] exp);
        sync();
        tbl_rd_req = 1; tbl_rd_addr = 5'(idx);
        sync();
        tbl_rd_req = 0;
        check({tag, "_ack"}, tbl_rd_ack, 1);
        check(tag, tbl_rd_data, exp);
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat was accepted
    task automatic drive_beat(input logic [255:0] d, input logic [127:0] u, input logic l,
                              output int acc);
        int g = 0;
        s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1;
        acc = -1;
        while (g < 200) begin
            @(negedge clk);
            if (s_tready) begin
                acc = cyc + 1;
                break;
            end
            g++;
        end
        if (acc < 0) check("in_timeout", s_tready, 1);
        @(posedge clk);
        #1;
        s_tvalid = 0;
    endtask

    task automatic send_pkt(input int nb, input logic [255:0] hd, input logic [127:0] hu,
                            output int acc0);
        logic [255:0] md, d;
        logic [127:0] mu, u;
        bit miss;
        int a;
        model(hd, hu, arp_lookup, nh_reg, oq_reg, md, mu, miss);
        if (miss) mdl_cnt = mdl_cnt + 1;
        e_data.push_back(md); e_user.push_back(mu); e_last.push_back(nb == 1);
        drive_beat(hd, hu, nb == 1, acc0);
        for (int b = 1; b < nb; b++) begin
            d = rand256();
            u = {$urandom, $urandom, $urandom, $urandom};
            e_data.push_back(d); e_user.push_back(u); e_last.push_back(b == nb - 1);
            drive_beat(d, u, b == nb - 1, a);
        end
    endtask

    task automatic wait_out(input int n);
        int g = 0;
        while (q_data.size() < n && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (q_data.size() < n) check("out_timeout", q_data.size(), n);
    endtask

    task automatic check_pkts(input string tag);
        int n = e_data.size();
        wait_out(n);
        for (int i = 0; i < n; i++) begin
            if (q_data.size() == 0) break;
            check({tag, "_data"}, q_data.pop_front(), e_data.pop_front());
            check({tag, "_user"}, q_user.pop_front(), e_user.pop_front());
            check({tag, "_last"}, q_last.pop_front(), e_last.pop_front());
            void'(q_cyc.pop_front());
        end
        e_data.delete(); e_user.delete(); e_last.delete();
        repeat (3) @(negedge clk);
        check({tag, "_extra"}, q_data.size(), 0);
        q_data.delete(); q_user.delete(); q_last.delete(); q_cyc.delete();
    endtask

    initial begin
        logic [255:0] hd, held;
        logic [127:0] hu;
        int acc0, a, g;
        logic [31:0] ip;

        oq_tab = '{8'h01, 8'h04, 8'h10, 8'h40, 8'h02};
        for (int i = 0; i < 32; i++) begin
            mdl_ip[i] = '0;
            mdl_mac[i] = '0;
        end
        mdl_cnt = 0;
        rst_n = 0;
        s_tdata = '0; s_tstrb = '1; s_tuser = '0; s_tvalid = 0; s_tlast = 0;
        m_tready = 1;
        arp_lookup = 0; nh_reg = 0; oq_reg = 0;
        tbl_wr_req = 0; tbl_rd_req = 0; tbl_wr_addr = 0; tbl_rd_addr = 0; tbl_wr_data = 0;
        reset_cnt = 0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        check("rst_wr_ack", tbl_wr_ack, 0);
        check("rst_rd_ack", tbl_rd_ack, 0);
        check("rst_rd_data", tbl_rd_data, 0);
        @(negedge clk);
        rst_n = 1;
        sync();
        check("s_tready_idle", s_tready, 1);

        // Hit, multi-beat
        tbl_write(3, {48'h001122334455, 32'h0A000001});
        sync();
        arp_lookup = 1; nh_reg = 32'h0A000001; oq_reg = 2;
        hd = rand256(); hd[79:72] = 8'd64; hd[63:48] = 16'hB1E6;
        hu = {$urandom, $urandom, $urandom, $urandom}; hu[23:16] = 8'h01;
        send_pkt(3, hd, hu, acc0);
        wait_out(3);
        if (q_data.size() >= 1) begin
            check("hit_mac", q_data[0][255:208], 48'h001122334455);
            check("hit_ttl", q_data[0][79:72], 8'd63);
            check("hit_csum", q_data[0][63:48], 16'hB2E6);
            check("hit_dst", q_user[0][31:24], 8'h10);
            check("hit_latency", q_cyc[0] - acc0, 2);
        end
        check_pkts("hit");
        check("hit_cnt", miss_cnt, 0);

        // Miss
        sync();
        arp_lookup = 1; nh_reg = 32'h0A000009; oq_reg = 1;
        hd = rand256();
        hu = {$urandom, $urandom, $urandom, $urandom}; hu[23:16] = 8'h04;
        send_pkt(2, hd, hu, acc0);
        wait_out(2);
        if (q_data.size() >= 1) begin
            check("miss_dst", q_user[0][31:24], 8'h08);
            check("miss_data", q_data[0], hd);
        end
        check_pkts("miss");
        check("miss_cnt", miss_cnt, 1);
        sync();
        reset_cnt = 32'd1;
        sync();
        reset_cnt = 32'd0;
        mdl_cnt = 0;
        check("cnt_clear", miss_cnt, 0);

        // Checksum wrap
        sync();
        arp_lookup = 1; nh_reg = 32'h0A000001; oq_reg = 0;
        hd = rand256(); hd[79:72] = 8'd1; hd[63:48] = 16'hFFFF;
        hu = {$urandom, $urandom, $urandom, $urandom}; hu[23:16] = 8'h10;
        send_pkt(1, hd, hu, acc0);
        wait_out(1);
        if (q_data.size() >= 1) begin
            check("wrap_csum", q_data[0][63:48], 16'h0100);
            check("wrap_ttl", q_data[0][79:72], 8'd0);
            check("wrap_dst", q_user[0][31:24], 8'h01);
        end
        check_pkts("wrap");

        // No lookup: passthrough
        sync();
        arp_lookup = 0; nh_reg = 32'h0A000001; oq_reg = 3;
        send_pkt(2, rand256(), {$urandom, $urandom, $urandom, $urandom}, acc0);
        check_pkts("pass");

        // Backpressure with back-to-back single-beat packets
        sync();
        m_tready = 0;
        arp_lookup = 1; nh_reg = 32'h0A000001; oq_reg = 4;
        for (int p = 0; p < 3; p++) begin
            hu = {$urandom, $urandom, $urandom, $urandom}; hu[23:16] = 8'h01;
            send_pkt(1, rand256(), hu, a);
        end
        @(negedge clk);
        check("bp_s_tready", s_tready, 0);
        g = 0;
        while (!m_tvalid && g < 50) begin
            @(negedge clk);
            g++;
        end
        held = m_tdata;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_valid", m_tvalid, 1);
            check("bp_hold_data", m_tdata, held);
        end
        sync();
        m_tready = 1;
        check_pkts("bp");

        // Same-cycle table write and read
        tbl_write(7, {48'hAABBCCDDEEFF, 32'hC0A80007});
        sync();
        tbl_wr_req = 1; tbl_wr_addr = 7; tbl_wr_data = {48'h0102030405AA, 32'hC0A80107};
        tbl_rd_req = 1; tbl_rd_addr = 7;
        sync();
        tbl_wr_req = 0; tbl_rd_req = 0;
        check("rw_old_data", tbl_rd_data, {48'hAABBCCDDEEFF, 32'hC0A80007});
        check("rw_wr_ack", tbl_wr_ack, 1);
        check("rw_rd_ack", tbl_rd_ack, 1);
        mdl_ip[7] = 32'hC0A80107; mdl_mac[7] = 48'h0102030405AA;
        sync();
        check("rw_wr_ack_pulse", tbl_wr_ack, 0);
        check("rw_rd_ack_pulse", tbl_rd_ack, 0);
        tbl_read("rd_new", 7, {48'h0102030405AA, 32'hC0A80107});

        // Randomized packets against the model
        for (int i = 10; i < 14; i++) begin
            ip = {8'd172, 24'($urandom)};
            tbl_write(i, {16'($urandom), 32'($urandom), ip});
        end
        tbl_write(20, {48'hDEADBEEF0020, mdl_ip[11]});
        for (int p = 0; p < 14; p++) begin
            sync();
            arp_lookup = ($urandom_range(0, 3) != 0);
            a = $urandom_range(0, 5);
            if (a < 4)       nh_reg = mdl_ip[10 + a];
            else if (a == 4) nh_reg = mdl_ip[7];
            else             nh_reg = $urandom;
            oq_reg = $urandom_range(0, 6);
            hd = rand256();
            hu = {$urandom, $urandom, $urandom, $urandom};
            hu[23:16] = 8'h55 & 8'($urandom);
            if (hu[23:16] == 8'h00) hu[23:16] = 8'h01;
            send_pkt($urandom_range(1, 3), hd, hu, acc0);
            check_pkts("rand");
        end
        check("rand_cnt", miss_cnt, mdl_cnt);

        // Reset during PAYLOAD
        sync();
        arp_lookup = 1; nh_reg = 32'h0A000001; oq_reg = 2;
        drive_beat(rand256(), 128'h0, 1'b0, a);
        drive_beat(rand256(), 128'h0, 1'b0, a);
        wait_out(2);
        sync();
        rst_n = 0;
        #1;
        check("mid_rst_m_tvalid", m_tvalid, 0);
        check("mid_rst_s_tready", s_tready, 0);
        check("mid_rst_cnt", miss_cnt, 0);
        check("mid_rst_rd_data", tbl_rd_data, 0);
        @(negedge clk);
        rst_n = 1;
        q_data.delete(); q_user.delete(); q_last.delete(); q_cyc.delete();
        for (int i = 0; i < 32; i++) begin
            mdl_ip[i] = '0;
            mdl_mac[i] = '0;
        end
        mdl_cnt = 0;
        tbl_read("rst_tbl_cleared", 3, 80'h0);
        sync();
        hd = rand256();
        hu = {$urandom, $urandom, $urandom, $urandom}; hu[23:16] = 8'h41;
        send_pkt(1, hd, hu, acc0);
        wait_out(1);
        if (q_data.size() >= 1) begin
            check("post_rst_dst", q_user[0][31:24], 8'h80);
            check("post_rst_data", q_data[0], hd);
        end
        check_pkts("post_rst");
        check("post_rst_cnt", miss_cnt, mdl_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arp_lookup_rewrite.md
# arp_lookup_rewrite

Router output-port-lookup stage placed directly downstream of the LPM stage. Consumes the per-packet LPM result (arp_lookup, nh_reg, oq_reg), resolves the next-hop IP to a destination MAC through a 32-entry ARP table, and rewrites the header beat. A hit rewrites the destination MAC, TTL, checksum and TUSER destination port. A miss or unresolved packet is steered to the CPU port paired with its source port.

## Interface
- C_M_AXIS_DATA_WIDTH, 256, master stream data width
- C_S_AXIS_DATA_WIDTH, 256, slave stream data width
- C_M_AXIS_TUSER_WIDTH, 128, master TUSER width
- C_S_AXIS_TUSER_WIDTH, 128, slave TUSER width
- SRC_PORT_POS, 16, LSB of the one-hot source-port byte in TUSER
- DST_PORT_POS, 24, LSB of the one-hot destination-port byte in TUSER
- Clocking/reset (already decided): one clock; reset is asynchronous and active-low.
- AXI_ACLK  in  1  sole clock
- AXI_RESETN  in  1  asynchronous active-low reset
- S_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST  in  256/32/128/1/1  packet stream from the LPM stage
- S_AXIS_TREADY  out  1  equals !input FIFO nearly_full; 0 while reset is asserted
- M_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST  out  256/32/128/1/1  rewritten packet stream
- M_AXIS_TREADY  in  1  downstream ready
- arp_lookup  in  1  LPM hit flag for the current packet
- nh_reg  in  32  next-hop IPv4 address
- oq_reg  in  32  output-queue index
- tbl_wr_req, tbl_rd_req  in  1 each  table access requests
- tbl_wr_addr, tbl_rd_addr  in  5 each  table index
- tbl_wr_data  in  80  entry written as {mac[47:0], ip[31:0]}
- tbl_rd_data  out  80  read entry
- tbl_wr_ack, tbl_rd_ack  out  1 each  one-cycle ack pulses
- reset  in  32  value 32'd1 clears arp_miss_count
- arp_miss_count  out  32  ARP miss counter

## Operation
- **Input buffering:** depth-4 fall-through FIFO; nearly_full asserts at 3 entries.
- **Sideband timing:** the sideband inputs are valid from the cycle after first-beat acceptance until last-beat acceptance. The block samples them only in LOOKUP.
- **Table:**
  - 32 entries, each 80 bits.
  - An entry is valid iff ip != 0.
  - Lookup compares nh_reg against all entries in parallel; the lowest matching index wins.
- **IDLE:** wait until the FIFO is non-empty, i.e. the first beat is at the head. Go to LOOKUP.
- **LOOKUP** (exactly 1 cycle): register arp_lookup, oq_reg, the hit flag and the matched MAC. Build the modified header beat. Go to HEADER.
- **HEADER:** present the modified beat with M_AXIS_TVALID=1.
  - On TREADY, pop the FIFO.
  - If TLAST, go to IDLE; otherwise go to PAYLOAD.
- **PAYLOAD:** pass beats unmodified. M_AXIS_TVALID = !empty. Pop on TVALID&TREADY. Go to IDLE after the TLAST beat transfers.
- **Rewrite when arp_lookup=1 and hit:**
  - TDATA[255:208] = MAC.
  - TDATA[79:72] = TTL-1, mod 256.
  - TDATA[63:48] = one's-complement sum of the checksum and 16'h0100, with end-around carry.
  - DST byte from oq_reg: 0→0x01, 1→0x04, 2→0x10, 3→0x40, 4→0x02. Any other value is treated as a miss.
- **arp_lookup=1 and no hit:**
  - Increment arp_miss_count.
  - DST byte set from the one-hot SRC byte: bit0→0x02, bit2→0x08, bit4→0x20, bit6→0x80. The highest set bit wins.
  - TDATA unchanged.
- **arp_lookup=0:** beat passed unchanged, including TUSER.
- **arp_miss_count:** wraps at 2^32. reset==1 clears it and overrides a same-cycle increment.
- **Table write:** on tbl_wr_req, write the entry; tbl_wr_ack=1 the next cycle.
- **Table read:** on tbl_rd_req, tbl_rd_data is registered from the pre-write contents; tbl_rd_ack=1 the next cycle.
- **Simultaneous read and write:** both are serviced; a same-address read returns old data.
- **Write during LOOKUP:** the lookup sees pre-write contents.

## Timing
- **Reset values:**
  - M_AXIS_TVALID=0, S_AXIS_TREADY=0.
  - arp_miss_count=0, tbl_wr_ack=0, tbl_rd_ack=0, tbl_rd_data=0.
  - State=IDLE, FIFO empty, all table entries 0 (invalid).
- **Latency:** the first beat appears on M_AXIS 2 cycles after it reaches the FIFO head (IDLE→LOOKUP→HEADER). Subsequent beats stream at 1/cycle when TREADY=1.
- **Backpressure:** the HEADER beat is registered and held stable while TREADY=0. Upstream stalls via S_AXIS_TREADY.
- **Single-beat packet:** HEADER→IDLE. The next packet may enter LOOKUP on the cycle after the transfer.
- **Reset mid-packet:** state returns to IDLE immediately, the FIFO is flushed, the partial packet is dropped and the table is cleared.
- **Miss count timing:** increments once per packet at the LOOKUP cycle.

## Test plan
- **Hit, multi-beat:** write entry 3 = {MAC 0x001122334455, IP 10.0.0.1}. Send a 3-beat packet with arp_lookup=1, nh=10.0.0.1, oq=2, TTL=64, csum=0xB1E6. Required: TDATA[255:208]=0x001122334455, TTL=63, csum=0xB2E6, DST=0x10, beats 2–3 unchanged, first beat out 2 cycles after head.
- **Miss:** nh=10.0.0.9, not in the table, SRC=0x04. Required: DST=0x08, TDATA unchanged, arp_miss_count=1. A following reset=1 pulse returns the count to 0.
- **Checksum wrap:** csum=0xFFFF, TTL=1. Required: csum=0x0100, TTL=0.
- **Backpressure and single-beat packets:** M_AXIS_TREADY low for 5 cycles in HEADER, then two back-to-back single-beat packets. Required: the held beat is stable, no beat is lost or duplicated, S_AXIS_TREADY drops at 3 queued beats.
- **Table access:** write and read to index 7 in the same cycle. Required: old data returned, both acks pulse 1 cycle later. A later read returns the new data.
- **Reset mid-packet:** assert AXI_RESETN low during PAYLOAD. Required: outputs go to reset values immediately, the count is 0, and the next lookup on any IP misses.
